// File: rtl/adder_result_display_pkg.sv
// Shared definitions for the adder result display: FSM encoding, BCD iteration
// count and active-low {g,f,e,d,c,b,a} segment patterns.
package adder_result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } disp_state_t;

    localparam int BCD_ITERS = 5;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/adder_result_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern, with a blank override.
module seg7_decode
    import adder_result_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/adder_result_display.sv
// Converts {cout,sum} to two BCD digits (double-dabble FSM) and scans them onto a
// 4-digit common-anode display. Define ADDER_DISP_LZ_BLANK_EN to blank a leading-zero tens digit.
module adder_result_display
    import adder_result_display_pkg::*;
#(
    parameter int SCAN_DIV = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sum,
    input  logic       cout,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    disp_state_t state_q, state_d;
    logic [12:0] shreg_q, shreg_d, adj;
    logic [2:0]  iter_q, iter_d;
    logic [3:0]  tens_q, tens_d, ones_q, ones_d;
    logic [CW-1:0] scan_q, scan_d;
    logic        sel_q, sel_d, wrap;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  digit;
    logic        blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            iter_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            scan_q  <= '0;
            sel_q   <= 1'b0;
            seg_q   <= SEG_0;
            an_q    <= 4'b1110;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            iter_q  <= iter_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // BCD field is shreg[12:5] (tens nibble [12:9], ones nibble [8:5]); binary below.
    always_comb begin
        adj = shreg_q;
        if (shreg_q[12:9] >= 4'd5) adj[12:9] = shreg_q[12:9] + 4'd3;
        if (shreg_q[8:5]  >= 4'd5) adj[8:5]  = shreg_q[8:5]  + 4'd3;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        iter_d  = iter_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_CONV;
                    shreg_d = {8'b0, cout, sum};
                    iter_d  = '0;
                end
            end
            ST_CONV: begin
                shreg_d = adj << 1;
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'(BCD_ITERS - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                tens_d  = shreg_q[12:9];
                ones_d  = shreg_q[8:5];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan mux selects on the next sel so seg and an always move together.
    always_comb begin
        wrap   = (scan_q == CW'(SCAN_DIV - 1));
        scan_d = wrap ? '0 : scan_q + 1'b1;
        sel_d  = sel_q ^ wrap;
        digit  = sel_d ? tens_q : ones_q;
        an_d   = sel_d ? 4'b1101 : 4'b1110;
`ifdef ADDER_DISP_LZ_BLANK_EN
        blank  = sel_d && (tens_q == 4'd0);
`else
        blank  = 1'b0;
`endif
    end

    seg7_decode u_seg7_decode (
        .bcd_i   (digit),
        .blank_i (blank),
        .seg_o   (seg_d)
    );

    assign busy = (state_q != ST_IDLE);
    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;

endmodule
